vote_result_sequencer: RTL and testbench

//  Downstream of the vote logger: consumes the per-candidate vote counts once result mode is entered.

---
 rtl/vote_pkg.sv | 31 +++
 rtl/vote_result_sequencer_if.sv | 39 +++
 rtl/vote_dwell_timer.sv | 42 ++++
 rtl/vote_result_sequencer.sv | 161 ++++++++++++++++
 tb/tb_vote_result_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/vote_pkg.sv
// ============================================================================
// vote_pkg : shared state encodings, default sizes and width helpers
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package vote_pkg;

  localparam int NUM_CAND_DEF = 4;
  localparam int CNT_W_DEF    = 8;
  localparam int STATE_W      = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_SNAP = 2'd1,
    S_SCAN = 2'd2,
    S_SHOW = 2'd3
  } state_e;

  // Display slot covers every candidate plus the trailing winner slot.
  function automatic int slot_w(input int num_cand);
    return $clog2(num_cand + 1);
  endfunction

  function automatic int idx_w(input int num_cand);
    return (num_cand > 1) ? $clog2(num_cand) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vote_result_sequencer_if.sv
// ============================================================================
// vote_result_sequencer_if : count input / result display bundle
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

interface vote_result_sequencer_if
  import vote_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEF,
  parameter int CNT_W    = CNT_W_DEF
) ();

  localparam int IDX_W  = idx_w(NUM_CAND);
  localparam int SLOT_W = slot_w(NUM_CAND);

  logic                      mode;
  logic [NUM_CAND*CNT_W-1:0] cand_votes;
  logic                      busy;
  logic                      result_valid;
  logic [IDX_W-1:0]          winner_idx;
  logic [CNT_W-1:0]          winner_count;
  logic                      tie;
  logic [SLOT_W-1:0]         disp_slot;
  logic [CNT_W-1:0]          disp_count;

  modport master (
    output mode, cand_votes,
    input  busy, result_valid, winner_idx, winner_count, tie, disp_slot, disp_count
  );

  modport slave (
    input  mode, cand_votes,
    output busy, result_valid, winner_idx, winner_count, tie, disp_slot, disp_count
  );

endinterface

`default_nettype wire

// File: rtl/vote_dwell_timer.sv
// ============================================================================
// vote_dwell_timer : counts 0..DWELL_CYCLES-1 while enabled, 1-cycle tick on wrap
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module vote_dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic en_i,
  input  wire logic clr_i,
  output logic      tick_o
);

  localparam int                CTR_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CTR_W-1:0]  LAST  = CTR_W'(DWELL_CYCLES - 1);

  logic [CTR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vote_result_sequencer.sv
// ============================================================================
// vote_result_sequencer : snapshot vote counts on result-mode entry, find the
// winner, then cycle the display through every count and the winner slot.
// Optional: VOTE_RESULT_TIE_DETECT_EN enables tie detection/blanking.
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module vote_result_sequencer
  import vote_pkg::*;
#(
  parameter int NUM_CAND     = NUM_CAND_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  wire logic              clk,
  input  wire logic              reset,
  vote_result_sequencer_if.slave bus
);

  localparam int                IDX_W    = idx_w(NUM_CAND);
  localparam int                SLOT_W   = slot_w(NUM_CAND);
  localparam logic [SLOT_W-1:0] WIN_SLOT = SLOT_W'(NUM_CAND);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_e             state_q, state_d;
  logic               mode_q;
  logic [CNT_W-1:0]   snap_q [NUM_CAND];
  logic               snap_load;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]   max_idx_q, max_idx_d;
  logic [CNT_W-1:0]   max_cnt_q, max_cnt_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               tie_acc_q, tie_acc_d;
  logic [CNT_W-1:0]   cur_cnt;
  logic               mode_rise;
  logic               show;
  logic               dwell_tick;

  assign mode_rise = bus.mode && !mode_q;
  assign show      = (state_q == S_SHOW);
  assign cur_cnt   = snap_q[scan_idx_q];

  vote_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .en_i   (show),
    .clr_i  (!show),
    .tick_o (dwell_tick)
  );

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    max_idx_d  = max_idx_q;
    max_cnt_d  = max_cnt_q;
    slot_d     = slot_q;
    tie_acc_d  = tie_acc_q;
    snap_load  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mode_rise) state_d = S_SNAP;
      end
      S_SNAP: begin
        snap_load  = 1'b1;
        scan_idx_d = '0;
        max_idx_d  = '0;
        max_cnt_d  = '0;
        tie_acc_d  = 1'b0;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        // A tie against a zero running max would flag the all-zero case.
        if (cur_cnt > max_cnt_q) begin
          max_idx_d = scan_idx_q;
          max_cnt_d = cur_cnt;
          tie_acc_d = 1'b0;
        end else if ((cur_cnt == max_cnt_q) && (max_cnt_q != '0)) begin
          tie_acc_d = 1'b1;
        end
        scan_idx_d = scan_idx_q + IDX_W'(1);
        if (scan_idx_q == LAST_IDX) begin
          state_d = S_SHOW;
          slot_d  = '0;
        end
      end
      S_SHOW: begin
        if (dwell_tick) begin
          slot_d = (slot_q == WIN_SLOT) ? '0 : slot_q + SLOT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && !bus.mode) begin
      state_d    = S_IDLE;
      scan_idx_d = '0;
      max_idx_d  = '0;
      max_cnt_d  = '0;
      slot_d     = '0;
      tie_acc_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      scan_idx_q <= '0;
      max_idx_q  <= '0;
      max_cnt_q  <= '0;
      slot_q     <= '0;
      tie_acc_q  <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= bus.mode;
      scan_idx_q <= scan_idx_d;
      max_idx_q  <= max_idx_d;
      max_cnt_q  <= max_cnt_d;
      slot_q     <= slot_d;
      tie_acc_q  <= tie_acc_d;
      if (snap_load) begin
        for (int i = 0; i < NUM_CAND; i++) snap_q[i] <= bus.cand_votes[i*CNT_W +: CNT_W];
      end
    end
  end

  logic tie_out;
`ifdef VOTE_RESULT_TIE_DETECT_EN
  assign tie_out = show && tie_acc_q;
`else
  assign tie_out = 1'b0;
  logic  unused_tie;
  assign unused_tie = tie_acc_q;
`endif

  assign bus.busy         = (state_q == S_SNAP) || (state_q == S_SCAN);
  assign bus.result_valid = show;
  assign bus.winner_idx   = show ? max_idx_q : '0;
  assign bus.winner_count = show ? max_cnt_q : '0;
  assign bus.tie          = tie_out;
  assign bus.disp_slot    = show ? slot_q : '0;

  always_comb begin
    bus.disp_count = '0;
    if (show) begin
      if (slot_q == WIN_SLOT) begin
        bus.disp_count = tie_out ? '0 : max_cnt_q;
      end else begin
        bus.disp_count = snap_q[slot_q[IDX_W-1:0]];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vote_result_sequencer.sv
// ============================================================================
// tb_vote_result_sequencer : directed self-checking bench, 4 candidates x 8 bit
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_vote_result_sequencer;

  localparam int NC    = 4;
  localparam int CW    = 8;
  localparam int DWELL = 4;
`ifdef VOTE_RESULT_TIE_DETECT_EN
  localparam bit TIE_EN = 1'b1;
`else
  localparam bit TIE_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  vote_result_sequencer_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();

  vote_result_sequencer #(
    .NUM_CAND     (NC),
    .CNT_W        (CW),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".valid"}, 32'(bus.result_valid), 0);
    check({tag, ".widx"}, 32'(bus.winner_idx), 0);
    check({tag, ".wcnt"}, 32'(bus.winner_count), 0);
    check({tag, ".tie"}, 32'(bus.tie), 0);
    check({tag, ".slot"}, 32'(bus.disp_slot), 0);
    check({tag, ".dcnt"}, 32'(bus.disp_count), 0);
  endtask

  task automatic check_result(input string tag, input int widx, input int wcnt, input int tie);
    check({tag, ".valid"}, 32'(bus.result_valid), 1);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".widx"}, 32'(bus.winner_idx), 32'(widx));
    check({tag, ".wcnt"}, 32'(bus.winner_count), 32'(wcnt));
    check({tag, ".tie"}, 32'(bus.tie), 32'(tie));
  endtask

  function automatic logic [NC*CW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(c0); b1 = 8'(c1); b2 = 8'(c2); b3 = 8'(c3);
    return {b3, b2, b1, b0};
  endfunction

  int exp_slot [6] = '{0, 1, 2, 3, 4, 0};
  int exp_dcnt [6] = '{3, 7, 2, 5, 7, 3};

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.mode       = 1'b0;
    bus.cand_votes = '0;
    step(3);
    check_zero("reset");
    reset = 1'b0;
    step(1);

    // Test 1: {3,7,2,5}, busy for SNAP + 4 SCAN cycles then result
    bus.cand_votes = pack4(3, 7, 2, 5);
    bus.mode       = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check($sformatf("t1.busy%0d", k), 32'(bus.busy), 1);
      check($sformatf("t1.valid%0d", k), 32'(bus.result_valid), 0);
    end
    step(1);
    check_result("t1", 1, 7, 0);

    // Test 2: display rotation, each slot held DWELL cycles
    for (int j = 0; j < 6; j++) begin
      for (int h = 0; h < DWELL; h++) begin
        if (!(j == 0 && h == 0)) step(1);
        check($sformatf("t2.slot%0d_%0d", j, h), 32'(bus.disp_slot), 32'(exp_slot[j]));
        check($sformatf("t2.dcnt%0d_%0d", j, h), 32'(bus.disp_count), 32'(exp_dcnt[j]));
      end
    end
    bus.mode = 1'b0;
    step(1);
    check_zero("t2.drop");

    // Test 3: {5,9,9,1} tie between candidates 1 and 2
    bus.cand_votes = pack4(5, 9, 9, 1);
    bus.mode       = 1'b1;
    step(6);
    check_result("t3", 1, 9, 32'(TIE_EN));
    step(4 * DWELL);
    check("t3.winslot", 32'(bus.disp_slot), 4);
    check("t3.windcnt", 32'(bus.disp_count), TIE_EN ? 0 : 9);
    bus.mode = 1'b0;
    step(1);
    check_zero("t3.drop");

    // Test 4: all counts zero
    bus.cand_votes = '0;
    bus.mode       = 1'b1;
    step(6);
    check_result("t4", 0, 0, 0);
    step(4 * DWELL);
    check("t4.winslot", 32'(bus.disp_slot), 4);
    check("t4.windcnt", 32'(bus.disp_count), 0);
    bus.mode = 1'b0;
    step(1);

    // Test 5: mode dropped at T+3 (mid-SCAN), then re-raised with new counts
    bus.cand_votes = pack4(1, 2, 3, 4);
    bus.mode       = 1'b1;
    step(3);
    check("t5.busy_mid", 32'(bus.busy), 1);
    bus.mode = 1'b0;
    step(1);
    check_zero("t5.abort");
    bus.cand_votes = pack4(4, 1, 1, 8);
    bus.mode       = 1'b1;
    step(6);
    check_result("t5.rerun", 3, 8, 0);
    check("t5.dcnt0", 32'(bus.disp_count), 4);
    bus.mode = 1'b0;
    step(1);

    // Test 6: counts change after SNAP, then reset during SHOW
    bus.cand_votes = pack4(2, 6, 6, 3);
    bus.mode       = 1'b1;
    step(2);
    bus.cand_votes = pack4(9, 0, 0, 0);
    step(4);
    check_result("t6.snap", 1, 6, 32'(TIE_EN));
    check("t6.dcnt0", 32'(bus.disp_count), 2);
    reset = 1'b1;
    step(1);
    check_zero("t6.reset");
    bus.mode = 1'b0;
    reset    = 1'b0;
    step(1);
    check_zero("t6.idle");
    bus.mode = 1'b1;
    step(6);
    check_result("t6.next", 0, 9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
